// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - byte-serialising CPU memory controller, data port over fetch; optional fetch buffer via MEM_CTRL_FETCH_BUF_EN
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_re,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_data,
  output logic              if_busy,
  output logic              if_done,
  input  logic              mem_re,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [3:0]        mem_sel,
  input  logic [31:0]       mem_wdata,
  output logic [31:0]       mem_rdata,
  output logic              mem_busy,
  output logic              mem_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [2:0]        cnt, cnt_nxt;
  logic              owner_data;
  logic [ADDR_W-1:0] base;
  logic [31:0]       wdata_q;
  logic [3:0]        wsel_q;

  logic [ADDR_W-1:0] if_base, mem_base;
  logic [1:0]        byte_idx;
  logic              fetch_hit;
  logic [31:0]       hit_data;
  logic              unused_bits;

  assign if_base     = {if_addr[ADDR_W-1:2], 2'b00};
  assign mem_base    = {mem_addr[ADDR_W-1:2], 2'b00};
  // The byte returned this cycle belongs to the address issued last cycle.
  assign byte_idx    = cnt[1:0] - 2'd1;
  assign unused_bits = ^{if_addr[1:0], mem_addr[1:0]};

`ifdef MEM_CTRL_FETCH_BUF_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_tag;
  logic [31:0]       buf_data;

  assign fetch_hit = buf_valid && (buf_tag == if_base) && !mem_we && !mem_re;
  assign hit_data  = buf_data;

  // Refill after every fetch; drop the entry when a write to that word is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_data  <= '0;
    end else if (state == S_DONE && !owner_data) begin
      buf_valid <= 1'b1;
      buf_tag   <= base;
      buf_data  <= if_data;
    end else if (state == S_IDLE && mem_we && mem_base == buf_tag) begin
      buf_valid <= 1'b0;
    end
  end
`else
  assign fetch_hit = 1'b0;
  assign hit_data  = 32'h0;
`endif

  // State, beat counter and per-transaction latches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= 3'd0;
      owner_data <= 1'b0;
      base       <= '0;
      wdata_q    <= '0;
      wsel_q     <= '0;
      if_data    <= '0;
      mem_rdata  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (state == S_IDLE) begin
        if (mem_we) begin
          owner_data <= 1'b1;
          base       <= mem_base;
          wdata_q    <= mem_wdata;
          wsel_q     <= mem_sel;
        end else if (mem_re) begin
          owner_data <= 1'b1;
          base       <= mem_base;
        end else if (if_re) begin
          owner_data <= 1'b0;
          base       <= if_base;
          if (fetch_hit) if_data <= hit_data;
        end
      end
      if (state == S_RD && cnt != 3'd0) begin
        if (owner_data) mem_rdata[8*byte_idx +: 8] <= ram_rdata;
        else            if_data[8*byte_idx +: 8]   <= ram_rdata;
      end
    end
  end

  // Next state: write beats read, data beats fetch; four beats per access.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        cnt_nxt = 3'd0;
        if (mem_we)      state_nxt = S_WR;
        else if (mem_re) state_nxt = S_RD;
        else if (if_re)  state_nxt = fetch_hit ? S_DONE : S_RD;
      end
      S_RD: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd4) begin
          state_nxt = S_DONE;
          cnt_nxt   = 3'd0;
        end
      end
      S_WR: begin
        cnt_nxt = cnt + 3'd1;
        if (cnt == 3'd3) begin
          state_nxt = S_DONE;
          cnt_nxt   = 3'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Port status and RAM drive, all derived from registered state.
  always_comb begin
    if_busy   = (state == S_RD || state == S_WR) && !owner_data;
    mem_busy  = (state == S_RD || state == S_WR) && owner_data;
    if_done   = (state == S_DONE) && !owner_data;
    mem_done  = (state == S_DONE) && owner_data;
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = 8'h0;
    if (state == S_RD && cnt <= 3'd3) begin
      ram_addr = base + ADDR_W'(cnt);
    end else if (state == S_WR) begin
      ram_addr  = base + ADDR_W'(cnt);
      ram_we    = wsel_q[cnt[1:0]];
      ram_wdata = wdata_q[8*cnt[1:0] +: 8];
    end
  end

endmodule
